// File: rtl/trig_buffer_manager.sv
// Trigger buffer manager: edge-detects trigger sources, allocates digitizer buffers in ring order.
// Optional per-source prescaler enabled by defining TRIG_PRESCALE_EN.
module trig_buffer_manager #(
    parameter int unsigned NUM_TRIG      = 4,
    parameter int unsigned NUM_BUF       = 4,
    parameter int unsigned BUF_BITS      = 2,
    parameter int unsigned HOLDOFF       = 16,
    parameter int unsigned PRESCALE_BITS = 8
) (
    input  logic                              clk250_i,
    input  logic                              rst_n_i,
    input  logic [NUM_TRIG-1:0]               trig_i,
    input  logic [NUM_TRIG-1:0]               trig_mask_i,
    input  logic [NUM_TRIG*PRESCALE_BITS-1:0] prescale_i,
    input  logic                              clear_i,
    input  logic [BUF_BITS-1:0]               clear_buffer_i,
    output logic                              digitize_o,
    output logic [BUF_BITS-1:0]               digitize_buffer_o,
    output logic [NUM_TRIG-1:0]               digitize_source_o,
    output logic [NUM_BUF-1:0]                HOLD_o,
    output logic [BUF_BITS:0]                 free_count_o,
    output logic                              dead_o,
    output logic [15:0]                       lost_count_o
);

    localparam int unsigned CntW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    typedef enum logic {StIdle, StHold} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [NUM_TRIG-1:0]   trig_q1, trig_q2;
    logic [NUM_TRIG-1:0]   trig_edge;
    logic [NUM_TRIG-1:0]   elig_q, elig_d;
    logic                  clear_q;
    logic [BUF_BITS-1:0]   clear_buf_q;
    logic [NUM_BUF-1:0]    occ_q, occ_d;
    logic [BUF_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic                  dig_q, dig_d;
    logic [BUF_BITS-1:0]   dig_buf_q, dig_buf_d;
    logic [NUM_TRIG-1:0]   dig_src_q, dig_src_d;
    logic                  dead_q, dead_d;
    logic [15:0]           lost_q, lost_d;
    logic                  accept;
    logic [BUF_BITS:0]     occ_ones;

    assign trig_edge = trig_q1 & ~trig_q2 & ~trig_mask_i;

`ifdef TRIG_PRESCALE_EN
    logic [NUM_TRIG-1:0][PRESCALE_BITS-1:0] psc_q, psc_d;

    always_comb begin
        psc_d  = psc_q;
        elig_d = '0;
        for (int unsigned s = 0; s < NUM_TRIG; s++) begin
            if (trig_edge[s]) begin
                if (psc_q[s] == prescale_i[s*PRESCALE_BITS +: PRESCALE_BITS]) begin
                    elig_d[s] = 1'b1;
                    psc_d[s]  = '0;
                end else begin
                    psc_d[s] = psc_q[s] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    logic unused_prescale;
    assign unused_prescale = ^prescale_i;
    assign elig_d          = trig_edge;
`endif

    // Eligible edges are registered once more so accept lands two edges after first sample.
    always_comb begin
        accept     = (state_q == StIdle) && !occ_q[wr_ptr_q] && (|elig_q);
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        occ_d      = occ_q;
        wr_ptr_d   = wr_ptr_q;
        dig_d      = 1'b0;
        dig_buf_d  = dig_buf_q;
        dig_src_d  = dig_src_q;
        lost_d     = lost_q;

        if (state_q == StHold) begin
            if (hold_cnt_q == CntW'(HOLDOFF - 1)) begin
                state_d = StIdle;
            end else begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end
        end

        if (clear_q) begin
            occ_d[clear_buf_q] = 1'b0;
        end

        if (accept) begin
            dig_d            = 1'b1;
            dig_buf_d        = wr_ptr_q;
            dig_src_d        = elig_q;
            occ_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            state_d          = StHold;
            hold_cnt_d       = '0;
        end else if ((|elig_q) && (lost_q != 16'hFFFF)) begin
            lost_d = lost_q + 16'd1;
        end

        dead_d = (state_d == StHold) | occ_q[wr_ptr_d];
    end

    always_ff @(posedge clk250_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            hold_cnt_q  <= '0;
            trig_q1     <= '0;
            trig_q2     <= '0;
            elig_q      <= '0;
            clear_q     <= 1'b0;
            clear_buf_q <= '0;
            occ_q       <= '0;
            wr_ptr_q    <= '0;
            dig_q       <= 1'b0;
            dig_buf_q   <= '0;
            dig_src_q   <= '0;
            dead_q      <= 1'b0;
            lost_q      <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            trig_q1     <= trig_i;
            trig_q2     <= trig_q1;
            elig_q      <= elig_d;
            clear_q     <= clear_i;
            clear_buf_q <= clear_buffer_i;
            occ_q       <= occ_d;
            wr_ptr_q    <= wr_ptr_d;
            dig_q       <= dig_d;
            dig_buf_q   <= dig_buf_d;
            dig_src_q   <= dig_src_d;
            dead_q      <= dead_d;
            lost_q      <= lost_d;
        end
    end

    always_comb begin
        occ_ones = '0;
        for (int unsigned b = 0; b < NUM_BUF; b++) begin
            occ_ones = occ_ones + {{BUF_BITS{1'b0}}, occ_q[b]};
        end
    end

    assign digitize_o        = dig_q;
    assign digitize_buffer_o = dig_buf_q;
    assign digitize_source_o = dig_src_q;
    assign HOLD_o            = occ_q;
    assign free_count_o      = (BUF_BITS + 1)'(NUM_BUF) - occ_ones;
    assign dead_o            = dead_q;
    assign lost_count_o      = lost_q;

endmodule

// File: doc/trig_buffer_manager.md
# trig_buffer_manager

Parametrised successor to the four-buffer trigger handler. It accepts NUM_TRIG trigger sources on the 250 MHz trigger clock. Each accepted event is allocated one of NUM_BUF digitizer buffers in ring order, and the block drives the per-buffer HOLD lines, the digitize command and the deadtime flag. It adds source masking, a programmable holdoff, a lost-trigger counter and an optional per-source prescaler. It sits between the RF/PPS/soft trigger sources and the event generator / event buffer readout.

## Interface
Parameters:
- NUM_TRIG, 4, number of trigger sources
- NUM_BUF, 4, number of digitizer buffers (power of 2, 2..16)
- BUF_BITS, 2, log2(NUM_BUF)
- HOLDOFF, 16, dead cycles after each accept (≥1)
- PRESCALE_BITS, 8, prescaler width per source

Ports:
- clk250_i  in  1  trigger clock, sole clock
- rst_n_i  in  1  reset, asynchronous, active-low
- trig_i  in  NUM_TRIG  trigger sources (level; rising edge used)
- trig_mask_i  in  NUM_TRIG  1 = source disabled
- prescale_i  in  NUM_TRIG*PRESCALE_BITS  per-source prescale; source s at [s*PRESCALE_BITS +: PRESCALE_BITS]
- clear_i  in  1  one-cycle pulse: release buffer clear_buffer_i
- clear_buffer_i  in  BUF_BITS  buffer to release
- digitize_o  out  1  one-cycle digitize strobe
- digitize_buffer_o  out  BUF_BITS  buffer allocated; held until next accept
- digitize_source_o  out  NUM_TRIG  sources that caused the accept; held until next accept
- HOLD_o  out  NUM_BUF  bit b high while buffer b occupied
- free_count_o  out  BUF_BITS+1  number of unoccupied buffers
- dead_o  out  1  high when no trigger can be accepted
- lost_count_o  out  16  rejected eligible edges, saturating

## Operation
- Edge detect: trig_i is registered twice; edge[s] = q1[s] & ~q2[s] & ~trig_mask_i[s].
- Eligible edge: an edge that passes the prescaler, or any edge when the prescaler is compiled out.
- Allocation pointer wr_ptr starts at 0. An accept requires state IDLE and !occupied[wr_ptr].
- Ring order is strict. If wr_ptr's buffer is occupied, the trigger is rejected even when other buffers are free.
- Accept actions, all registered:
  - digitize_o=1 for one cycle
  - digitize_buffer_o=wr_ptr
  - digitize_source_o = all eligible edges in that cycle
  - occupied[wr_ptr] set
  - wr_ptr incremented modulo NUM_BUF
  - state goes to HOLD
- State machine:
  - IDLE → HOLD on accept.
  - HOLD counts HOLDOFF cycles, then returns to IDLE.
  - No other states.
- dead_o = (state==HOLD) | occupied[wr_ptr], registered.
- Rejected edges: any eligible edge arriving while dead increments lost_count_o by 1 per cycle. Multiple sources in one cycle count as 1. The counter saturates at 0xFFFF.
- Clear: clear_i clears occupied[clear_buffer_i]. Clearing an unoccupied buffer is ignored.
- Simultaneous clear and accept in the same cycle both take effect. Clearing wr_ptr's buffer in a cycle where it blocks acceptance permits acceptance the following cycle.
- free_count_o = NUM_BUF − popcount(occupied); HOLD_o = occupied.

## Timing
- Reset (rst_n_i low, asynchronous): every output is 0 except free_count_o=NUM_BUF. wr_ptr=0, state IDLE, edge registers, prescalers and lost counter are all 0.
- Reset mid-event aborts the event immediately; no digitize_o is issued after reset release.
- Latency: trig_i first sampled high at edge N → digitize_o and HOLD_o bit high after edge N+2.
- dead_o rises with digitize_o and stays high HOLDOFF cycles. It stays high longer if the next ring buffer is occupied.
- Clear: clear_i sampled at edge N → HOLD_o bit low and free_count_o updated after edge N+1. dead_o updates after edge N+2.
- Minimum accept spacing: HOLDOFF+1 cycles.

## Configuration
- TRIG_PRESCALE_EN defined: each source has a PRESCALE_BITS edge counter, cleared on reset.
  - An unmasked edge with counter==prescale_i[s] is eligible and resets the counter to 0. Otherwise the counter increments.
  - Prescale 0 passes every edge; N passes every (N+1)th edge.
  - The prescaler counts edges regardless of dead_o.
- TRIG_PRESCALE_EN undefined: prescale_i is ignored and every unmasked edge is eligible.

## Test plan
- Single trig_i[0] pulse after reset → digitize_o at cycle N+2, digitize_buffer_o=0, digitize_source_o=4'b0001, HOLD_o=4'b0001, free_count_o=3.
- trig_i[0] and trig_i[3] rising in the same cycle → exactly one digitize_o with digitize_source_o=4'b1001; lost_count_o stays 0.
- Five triggers spaced 20 cycles apart with no clears (NUM_BUF=4) → buffers 0,1,2,3 accepted; the fifth is rejected; dead_o stays high and lost_count_o=1. Then clear_i with clear_buffer_i=0 → the next trigger is accepted into buffer 0.
- Second trigger 5 cycles after the first (HOLDOFF=16) → rejected, lost_count_o=1. A trigger 17 cycles after the first accept is accepted into buffer 1.
- Prescale_i[0]=2 with TRIG_PRESCALE_EN defined, 9 spaced edges → 3 accepts, on the 3rd, 6th and 9th edges. With the macro undefined → 4 accepts, then the next 5 edges are lost, because no clears are applied.
- rst_n_i asserted one cycle after trig_i sampled high → no digitize_o; all outputs are at reset values, including free_count_o=NUM_BUF.
